// File: rtl/eth_block_framer.sv
// eth_block_framer: reads 256-word blocks from two ADC FIFOs (round-robin) and emits header+data frames to the MAC
//
// Ports:
//   clk, rst_n                     MAC transmit clock (also FIFO read clock), async active-low reset
//   enable                         permits new frames; a frame in progress always completes
//   is_there_256_1/2               FIFO 1/2 holds at least BLOCK_LEN words
//   data_blocks1/2, rdreq1/2       FIFO 1/2 dout (valid one cycle after rdreq) and read enable
//   tx_ready                       MAC can take a whole frame, sampled only in IDLE
//   tx_data/valid/sop/eop          registered frame stream: HDR_WORDS header words then BLOCK_LEN data words
//   pkt_cnt                        frames completed since reset
//   busy                           high whenever the framer is not IDLE
module eth_block_framer #(
   parameter int          BLOCK_LEN = 256,
   parameter int          HDR_WORDS = 4,
   parameter int          GAP_CYC   = 12,
   parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        is_there_256_1,
   input  logic        is_there_256_2,
   input  logic [15:0] data_blocks1,
   input  logic [15:0] data_blocks2,
   output logic        rdreq1,
   output logic        rdreq2,
   input  logic        tx_ready,
   output logic [15:0] tx_data,
   output logic        tx_valid,
   output logic        tx_sop,
   output logic        tx_eop,
   output logic [31:0] pkt_cnt,
   output logic        busy
);
   localparam int FRAME_LEN = HDR_WORDS + BLOCK_LEN;
   localparam int IW        = $clog2(FRAME_LEN);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d, nxt;
   logic          ch_q, ch_d, last_ch_q, last_ch_d;
   logic [31:0]   pkt_cnt_q, pkt_cnt_d;
   logic [15:0]   tx_data_q, tx_data_d, dout, hdr;
   logic          tx_valid_q, tx_valid_d, tx_sop_q, tx_sop_d, tx_eop_q, tx_eop_d;
   logic          start, sel, rd_win;

   // idx_q is the index of the word currently on tx_data in SEND, and the idle-cycle count in GAP
   assign nxt   = idx_q + 1'b1;
   assign start = enable && tx_ready && (is_there_256_1 || is_there_256_2);
   // ch = 0 selects FIFO 1, ch = 1 selects FIFO 2; a tie goes to the channel not served last
   assign sel   = (is_there_256_1 && is_there_256_2) ? ~last_ch_q : ~is_there_256_1;
   assign dout  = ch_q ? data_blocks2 : data_blocks1;
   assign hdr   = (nxt == IW'(1)) ? {15'd0, ch_q} : (nxt == IW'(2)) ? pkt_cnt_q[31:16] : pkt_cnt_q[15:0];
   // Read two words ahead: rdreq at t, FIFO dout at t+1, tx_data at t+2
   assign rd_win = (state_q == SEND) && (idx_q >= IW'(HDR_WORDS - 2)) && (idx_q <= IW'(FRAME_LEN - 3));

   assign rdreq1   = rd_win && !ch_q;
   assign rdreq2   = rd_win && ch_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign tx_sop   = tx_sop_q;
   assign tx_eop   = tx_eop_q;
   assign pkt_cnt  = pkt_cnt_q;
   assign busy     = state_q != IDLE;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      ch_d       = ch_q;
      last_ch_d  = last_ch_q;
      pkt_cnt_d  = pkt_cnt_q;
      tx_data_d  = '0;
      tx_valid_d = 1'b0;
      tx_sop_d   = 1'b0;
      tx_eop_d   = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d    = SEND;
            idx_d      = '0;
            ch_d       = sel;
            tx_data_d  = SYNC_WORD;
            tx_valid_d = 1'b1;
            tx_sop_d   = 1'b1;
         end
         SEND: if (idx_q == IW'(FRAME_LEN - 1)) begin
            state_d   = GAP;
            idx_d     = '0;
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            last_ch_d = ch_q;
         end else begin
            idx_d      = nxt;
            tx_valid_d = 1'b1;
            tx_eop_d   = nxt == IW'(FRAME_LEN - 1);
            tx_data_d  = (nxt >= IW'(HDR_WORDS)) ? dout : hdr;
         end
         GAP: begin
            idx_d   = nxt;
            state_d = (idx_q == IW'(GAP_CYC - 1)) ? IDLE : GAP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         ch_q       <= 1'b0;
         last_ch_q  <= 1'b1;
         pkt_cnt_q  <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         tx_sop_q   <= 1'b0;
         tx_eop_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         ch_q       <= ch_d;
         last_ch_q  <= last_ch_d;
         pkt_cnt_q  <= pkt_cnt_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         tx_sop_q   <= tx_sop_d;
         tx_eop_q   <= tx_eop_d;
      end
   end
endmodule

// File: tb/tb_eth_block_framer.sv
// tb_eth_block_framer: directed self-checking bench for eth_block_framer with two counting FIFO models
module tb_eth_block_framer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0, tx_ready = 1'b0, f1 = 1'b0, f2 = 1'b0;
   logic [15:0] d1, d2, p1, p2, tx_data;
   logic        rdreq1, rdreq2, tx_valid, tx_sop, tx_eop, busy;
   logic [31:0] pkt_cnt;
   int          n_cmp = 0, n_bad = 0, cyc = 0;

   logic [15:0] w  [260];
   bit          v  [260], so [260], eo [260], r1 [260], r2 [260];
   bit          found;
   int          sop_cyc;

   eth_block_framer dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .is_there_256_1(f1), .is_there_256_2(f2),
      .data_blocks1(d1), .data_blocks2(d2),
      .rdreq1(rdreq1), .rdreq2(rdreq2), .tx_ready(tx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop),
      .pkt_cnt(pkt_cnt), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // FIFO models: each read returns the next value of a counter starting at 0 after reset
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin p1 <= '0; d1 <= '0; end
      else if (rdreq1) begin d1 <= p1; p1 <= p1 + 16'd1; end
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin p2 <= '0; d2 <= '0; end
      else if (rdreq2) begin d2 <= p2; p2 <= p2 + 16'd1; end

   task automatic do_reset();
      rst_n = 1'b0; enable = 1'b0; tx_ready = 1'b0; f1 = 1'b0; f2 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Waits (bounded) for tx_sop and records 260 cycles starting there; ends at the negedge of S+260
   task automatic capture(input int drop_at);
      found = 1'b0;
      for (int t = 0; t < 400 && !found; t++) begin
         @(negedge clk);
         found = tx_sop;
      end
      if (!found) begin
         n_cmp++; n_bad++;
         $display("FAIL sop_timeout: got no tx_sop in 400 cycles, required one");
         return;
      end
      sop_cyc = cyc;
      for (int i = 0; i < 260; i++) begin
         if (i == drop_at) enable = 1'b0;
         w[i] = tx_data; v[i] = tx_valid; so[i] = tx_sop; eo[i] = tx_eop; r1[i] = rdreq1; r2[i] = rdreq2;
         @(negedge clk);
      end
   endtask

   // Counts deviations of the captured frame from the required cycle-by-cycle shape
   function automatic int frame_errs(input bit ch, input logic [15:0] base);
      int  e = 0;
      bit  rq;
      for (int i = 0; i < 260; i++) begin
         rq = (i >= 2) && (i <= 257);
         if (!v[i]) e++;
         if (so[i] != (i == 0)) e++;
         if (eo[i] != (i == 259)) e++;
         if (r1[i] != (rq && !ch)) e++;
         if (r2[i] != (rq && ch)) e++;
         if (i >= 4 && w[i] !== 16'(int'(base) + i - 4)) e++;
      end
      return e;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({tx_data, tx_valid, tx_sop, tx_eop, rdreq1, rdreq2, busy} !== 22'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got data=%h v=%b sop=%b eop=%b rd1=%b rd2=%b busy=%b, required all 0",
                  tx_data, tx_valid, tx_sop, tx_eop, rdreq1, rdreq2, busy);
      end
      n_cmp++;
      if (pkt_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_pkt_cnt: got %h, required 0", pkt_cnt); end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({tx_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL idle_disabled: got v=%b busy=%b, required 0 0", tx_valid, busy); end
   endtask

   task automatic test_single_ch1();
      int e;
      enable = 1'b1; tx_ready = 1'b1; f1 = 1'b1;
      capture(-1);
      f1 = 1'b0;
      n_cmp++;
      if ({w[0], w[1], w[2], w[3]} !== {16'hA55A, 16'h0000, 16'h0000, 16'h0000}) begin
         n_bad++; $display("FAIL single_header: got %h %h %h %h, required a55a 0000 0000 0000", w[0], w[1], w[2], w[3]);
      end
      e = frame_errs(1'b0, 16'd0);
      n_cmp++;
      if (e !== 0) begin n_bad++; $display("FAIL single_frame_shape: got %0d deviations, required 0", e); end
      n_cmp++;
      if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_after: got %b, required 0", tx_valid); end
      n_cmp++;
      if (pkt_cnt !== 32'd1) begin n_bad++; $display("FAIL single_pkt_cnt: got %0d, required 1", pkt_cnt); end
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_gap: got %b, required 1", busy); end
   endtask

   task automatic test_round_robin();
      int e, prev_eop, gap;
      do_reset();
      enable = 1'b1; tx_ready = 1'b1; f1 = 1'b1; f2 = 1'b1;
      prev_eop = 0;
      for (int j = 0; j < 4; j++) begin
         capture(-1);
         if (j == 3) begin enable = 1'b0; f1 = 1'b0; f2 = 1'b0; end
         n_cmp++;
         if (w[1] !== 16'(j % 2)) begin n_bad++; $display("FAIL rr_w1_%0d: got %h, required %h", j, w[1], j % 2); end
         n_cmp++;
         if ({w[2], w[3]} !== {16'd0, 16'(j)}) begin n_bad++; $display("FAIL rr_w23_%0d: got %h %h, required 0000 %h", j, w[2], w[3], j); end
         e = frame_errs(j[0], 16'((j / 2) * 256));
         n_cmp++;
         if (e !== 0) begin n_bad++; $display("FAIL rr_shape_%0d: got %0d deviations, required 0", j, e); end
         if (j > 0) begin
            gap = sop_cyc - prev_eop - 1;
            n_cmp++;
            if (gap < 12) begin n_bad++; $display("FAIL rr_gap_%0d: got %0d idle cycles, required >= 12", j, gap); end
         end
         prev_eop = sop_cyc + 259;
      end
   endtask

   task automatic test_gating();
      int e, bad;
      repeat (20) @(negedge clk);
      enable = 1'b1; tx_ready = 1'b0; f1 = 1'b1;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx_valid || rdreq1 || rdreq2 || busy) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL gate_tx_ready: got %0d active cycles, required 0", bad); end
      tx_ready = 1'b1;
      capture(100);
      n_cmp++;
      if ({w[1], w[3]} !== {16'd0, 16'd4}) begin n_bad++; $display("FAIL gate_header: got w1=%h w3=%h, required 0000 0004", w[1], w[3]); end
      e = frame_errs(1'b0, 16'd512);
      n_cmp++;
      if (e !== 0) begin n_bad++; $display("FAIL gate_complete: got %0d deviations, required 0", e); end
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_valid || tx_sop) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL gate_no_restart: got %0d valid cycles, required 0", bad); end
      f1 = 1'b0;
   endtask

   task automatic test_reset_mid();
      int e;
      enable = 1'b1; tx_ready = 1'b1; f1 = 1'b1;
      found = 1'b0;
      for (int t = 0; t < 400 && !found; t++) begin
         @(negedge clk);
         found = tx_sop;
      end
      n_cmp++;
      if (!found) begin n_bad++; $display("FAIL mid_sop: got no tx_sop in 400 cycles, required one"); end
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({tx_valid, rdreq1, rdreq2, busy} !== 4'b0000) begin
         n_bad++; $display("FAIL mid_reset_outputs: got v=%b rd1=%b rd2=%b busy=%b, required 0", tx_valid, rdreq1, rdreq2, busy);
      end
      n_cmp++;
      if (pkt_cnt !== 32'd0) begin n_bad++; $display("FAIL mid_reset_pkt_cnt: got %0d, required 0", pkt_cnt); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      capture(-1);
      f1 = 1'b0; enable = 1'b0;
      n_cmp++;
      if ({w[0], w[1], w[2], w[3]} !== {16'hA55A, 16'h0000, 16'h0000, 16'h0000}) begin
         n_bad++; $display("FAIL mid_clean_header: got %h %h %h %h, required a55a 0000 0000 0000", w[0], w[1], w[2], w[3]);
      end
      e = frame_errs(1'b0, 16'd0);
      n_cmp++;
      if (e !== 0) begin n_bad++; $display("FAIL mid_clean_shape: got %0d deviations, required 0", e); end
      n_cmp++;
      if (pkt_cnt !== 32'd1) begin n_bad++; $display("FAIL mid_clean_pkt_cnt: got %0d, required 1", pkt_cnt); end
   endtask

   task automatic test_wrap();
      int e;
      repeat (20) @(negedge clk);
      force dut.pkt_cnt_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.pkt_cnt_q;
      @(negedge clk);
      n_cmp++;
      if (pkt_cnt !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_preset: got %h, required ffffffff", pkt_cnt); end
      enable = 1'b1; tx_ready = 1'b1; f1 = 1'b1;
      capture(-1);
      f1 = 1'b0; enable = 1'b0;
      n_cmp++;
      if ({w[1], w[2], w[3]} !== {16'h0000, 16'hFFFF, 16'hFFFF}) begin
         n_bad++; $display("FAIL wrap_header: got %h %h %h, required 0000 ffff ffff", w[1], w[2], w[3]);
      end
      e = frame_errs(1'b0, 16'd256);
      n_cmp++;
      if (e !== 0) begin n_bad++; $display("FAIL wrap_shape: got %0d deviations, required 0", e); end
      n_cmp++;
      if (pkt_cnt !== 32'd0) begin n_bad++; $display("FAIL wrap_pkt_cnt: got %h, required 00000000", pkt_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_ch1();
      test_round_robin();
      test_gating();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
